// File: rtl/serial_frame_receiver.sv
// Oversampling start/data/parity/stop frame receiver with a sync-word gate
// that releases a payload only after a matching sync frame.
module serial_frame_receiver #(
  parameter int CLKS_PER_BIT = 128,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_EN      = 1,
  parameter logic [DATA_BITS-1:0] SYNC_WORD = 'h55
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 sync_locked,
  output logic [DATA_BITS-1:0] payload,
  output logic                 payload_valid
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state, state_next;
  logic                 rs_meta, rs, rs_prev;
  logic [1:0]           flush;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad, stop_bad;
  logic                 tick, par_fail, frame_done, line_ok;
  logic                 done_clean, done_perr, done_ferr;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  // rs_prev only tracks the line once the synchroniser holds real samples,
  // so a line already low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta <= 1'b1;
      rs      <= 1'b1;
      flush   <= 2'b00;
      rs_prev <= 1'b0;
    end else begin
      rs_meta <= rx;
      rs      <= rs_meta;
      flush   <= {flush[0], 1'b1};
      rs_prev <= flush[1] & rs;
    end
  end

  assign tick       = (state == S_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);
  assign par_fail   = (PARITY_MODE == 2) ? ~(^{shift, rs}) : (^{shift, rs});
  assign frame_done = (state == S_STOP) && tick && (stop_idx == STOP_LAST);
  assign line_ok    = ~stop_bad & rs;
  assign done_clean = frame_done & line_ok & ~par_bad;
  assign done_perr  = frame_done & line_ok & par_bad;
  assign done_ferr  = frame_done & ~line_ok;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (!rs && rs_prev) state_next = S_START;
      S_START:     if (tick) state_next = rs ? S_IDLE : S_DATA;
      S_DATA:      if (tick && bit_idx == BIT_LAST)
                     state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (tick) state_next = S_STOP;
      S_STOP:      if (frame_done) state_next = line_ok ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rs) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      cnt <= (state == S_IDLE || tick) ? '0 : cnt + 1'b1;
      if (state == S_IDLE) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end else if (tick) begin
        case (state)
          S_DATA: begin
            shift   <= {rs, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          S_PARITY: par_bad <= par_fail;
          S_STOP: begin
            stop_idx <= ~stop_idx;
            if (!rs) stop_bad <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame outcomes and the sync-word gate; a payload is released only on the
  // first clean frame after a sync word, and any error drops the lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data          <= '0;
      data_valid    <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      sync_locked   <= 1'b0;
      payload       <= '0;
      payload_valid <= 1'b0;
    end else begin
      data_valid    <= done_clean;
      parity_err    <= done_perr;
      frame_err     <= done_ferr;
      payload_valid <= 1'b0;
      if (done_clean) data <= shift;
      if (SYNC_EN == 0) begin
        if (done_clean) begin
          payload       <= shift;
          payload_valid <= 1'b1;
        end
      end else if (done_clean) begin
        if (sync_locked) begin
          payload       <= shift;
          payload_valid <= 1'b1;
          sync_locked   <= 1'b0;
        end else if (shift == SYNC_WORD) begin
          sync_locked <= 1'b1;
        end
      end else if (done_perr || done_ferr) begin
        sync_locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench: an 8N1 receiver and an 8E1 receiver, both sync-gated,
// driven from a frame table plus glitch, line-break and mid-frame reset cases.
module tb_serial_frame_receiver;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rx_p = 1'b1;

  logic [7:0] m_data, m_payload, p_data, p_payload;
  logic m_dv, m_pe, m_fe, m_busy, m_sync, m_pv;
  logic p_dv, p_pe, p_fe, p_busy, p_sync, p_pv;

  serial_frame_receiver #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
    .SYNC_EN(1), .SYNC_WORD(8'h55)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(m_data), .data_valid(m_dv),
    .parity_err(m_pe), .frame_err(m_fe), .busy(m_busy), .sync_locked(m_sync),
    .payload(m_payload), .payload_valid(m_pv)
  );

  serial_frame_receiver #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
    .SYNC_EN(1), .SYNC_WORD(8'h55)
  ) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .data(p_data), .data_valid(p_dv),
    .parity_err(p_pe), .frame_err(p_fe), .busy(p_busy), .sync_locked(p_sync),
    .payload(p_payload), .payload_valid(p_pv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start[2];
  int dv_cnt[2], pe_cnt[2], fe_cnt[2], pv_cnt[2], busy_rise[2];
  int lat[2], pv_lat[2];
  logic busy_q[2];

  logic [7:0] data_w[2], payload_w[2];
  logic       dv_w[2], pe_w[2], fe_w[2], pv_w[2], busy_w[2], sync_w[2];
  assign data_w[0] = m_data;    assign data_w[1] = p_data;
  assign payload_w[0] = m_payload; assign payload_w[1] = p_payload;
  assign dv_w[0] = m_dv;        assign dv_w[1] = p_dv;
  assign pe_w[0] = m_pe;        assign pe_w[1] = p_pe;
  assign fe_w[0] = m_fe;        assign fe_w[1] = p_fe;
  assign pv_w[0] = m_pv;        assign pv_w[1] = p_pv;
  assign busy_w[0] = m_busy;    assign busy_w[1] = p_busy;
  assign sync_w[0] = m_sync;    assign sync_w[1] = p_sync;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      dv_cnt[i] = 0; pe_cnt[i] = 0; fe_cnt[i] = 0; pv_cnt[i] = 0;
      busy_rise[i] = 0; lat[i] = -1; pv_lat[i] = -1; busy_q[i] = 1'b0;
      t_start[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dv_w[i]) dv_cnt[i] = dv_cnt[i] + 1;
      if (pe_w[i]) pe_cnt[i] = pe_cnt[i] + 1;
      if (fe_w[i]) fe_cnt[i] = fe_cnt[i] + 1;
      if (pv_w[i]) begin
        pv_cnt[i] = pv_cnt[i] + 1;
        pv_lat[i] = cyc - t_start[i];
      end
      if (dv_w[i] || pe_w[i] || fe_w[i]) lat[i] = cyc - t_start[i];
      if (busy_w[i] && !busy_q[i]) busy_rise[i] = busy_rise[i] + 1;
      busy_q[i] = busy_w[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int w, input logic v);
    if (w == 1) rx_p = v;
    else        rx = v;
  endtask

  // Called at a rising edge; each bit is held for CPB clocks.
  task automatic drive_bit(input int w, input logic v);
    #1 set_line(w, v);
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic sbit);
    @(posedge clk);
    #1 set_line(w, 1'b0);
    t_start[w] = cyc;
    repeat (CPB) @(posedge clk);
    for (int k = 0; k < 8; k++) drive_bit(w, d[k]);
    if (has_par) drive_bit(w, pbit);
    drive_bit(w, sbit);
    drive_bit(w, 1'b1);
    drive_bit(w, 1'b1);
  endtask

  typedef struct {
    int         w;
    logic [7:0] d;
    logic       par_bit;
    logic       stop_bit;
    logic       exp_dv, exp_pe, exp_fe, exp_pv;
    logic [7:0] exp_data, exp_payload;
    logic       exp_sync;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish, cycle %0d, limit 200000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s_dv, s_pe, s_fe, s_pv, s_br, exp_lat;
    vec_t v;

    //           w  d      pb    sb    dv pe fe pv data   payload sync
    vecs[0]  = '{0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 0, 8'h3C, 8'h00, 0};
    vecs[1]  = '{0, 8'h55, 1'b0, 1'b1, 1, 0, 0, 0, 8'h55, 8'h00, 1};
    vecs[2]  = '{0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 1, 8'h3C, 8'h3C, 0};
    vecs[3]  = '{0, 8'h55, 1'b0, 1'b1, 1, 0, 0, 0, 8'h55, 8'h3C, 1};
    vecs[4]  = '{0, 8'h55, 1'b0, 1'b1, 1, 0, 0, 1, 8'h55, 8'h55, 0};
    vecs[5]  = '{0, 8'h55, 1'b0, 1'b1, 1, 0, 0, 0, 8'h55, 8'h55, 1};
    vecs[6]  = '{0, 8'h12, 1'b0, 1'b0, 0, 0, 1, 0, 8'h55, 8'h55, 0};
    vecs[7]  = '{0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 0, 8'hA5, 8'h55, 0};
    vecs[8]  = '{1, 8'h55, 1'b0, 1'b1, 1, 0, 0, 0, 8'h55, 8'h00, 1};
    vecs[9]  = '{1, 8'h55, 1'b1, 1'b1, 0, 1, 0, 0, 8'h55, 8'h00, 0};
    vecs[10] = '{1, 8'h07, 1'b1, 1'b1, 1, 0, 0, 0, 8'h07, 8'h00, 0};
    vecs[11] = '{1, 8'h07, 1'b0, 1'b1, 0, 1, 0, 0, 8'h07, 8'h00, 0};
    vecs[12] = '{1, 8'h55, 1'b0, 1'b1, 1, 0, 0, 0, 8'h55, 8'h00, 1};
    vecs[13] = '{1, 8'h81, 1'b0, 1'b1, 1, 0, 0, 1, 8'h81, 8'h81, 0};

    // Reset state of both receivers
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst%0d_data", w), 32'(data_w[w]), 32'h0);
      check($sformatf("rst%0d_payload", w), 32'(payload_w[w]), 32'h0);
      check($sformatf("rst%0d_flags", w),
            32'({dv_w[w], pe_w[w], fe_w[w], pv_w[w], busy_w[w], sync_w[w]}), 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      s_dv = dv_cnt[v.w]; s_pe = pe_cnt[v.w]; s_fe = fe_cnt[v.w]; s_pv = pv_cnt[v.w];
      send_frame(v.w, v.d, (v.w == 1), v.par_bit, v.stop_bit);
      @(negedge clk);
      exp_lat = 2 + CPB / 2 + (8 + v.w + 1) * CPB + 1;
      check($sformatf("v%0d_dv", i), 32'(dv_cnt[v.w] - s_dv), 32'(v.exp_dv));
      check($sformatf("v%0d_pe", i), 32'(pe_cnt[v.w] - s_pe), 32'(v.exp_pe));
      check($sformatf("v%0d_fe", i), 32'(fe_cnt[v.w] - s_fe), 32'(v.exp_fe));
      check($sformatf("v%0d_pv", i), 32'(pv_cnt[v.w] - s_pv), 32'(v.exp_pv));
      check($sformatf("v%0d_data", i), 32'(data_w[v.w]), 32'(v.exp_data));
      check($sformatf("v%0d_payload", i), 32'(payload_w[v.w]), 32'(v.exp_payload));
      check($sformatf("v%0d_sync", i), 32'(sync_w[v.w]), 32'(v.exp_sync));
      check($sformatf("v%0d_latency", i), 32'(lat[v.w]), 32'(exp_lat));
      if (v.exp_pv) check($sformatf("v%0d_pv_latency", i), 32'(pv_lat[v.w]), 32'(exp_lat));
      check($sformatf("v%0d_idle", i), 32'(busy_w[v.w]), 32'h0);
    end

    // Short low glitch: false start, busy pulses once, no outcome
    s_dv = dv_cnt[0]; s_pe = pe_cnt[0]; s_fe = fe_cnt[0]; s_br = busy_rise[0];
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_pulses", 32'(busy_rise[0] - s_br), 32'd1);
    check("glitch_outcomes", 32'((dv_cnt[0] - s_dv) + (pe_cnt[0] - s_pe) + (fe_cnt[0] - s_fe)), 32'd0);
    check("glitch_idle", 32'(m_busy), 32'h0);

    // Line break of 30 bit periods: one frame_err, busy held until line high
    s_dv = dv_cnt[0]; s_fe = fe_cnt[0]; s_br = busy_rise[0];
    @(posedge clk);
    #1 rx = 1'b0;
    t_start[0] = cyc;
    repeat (30 * CPB) @(posedge clk);
    @(negedge clk);
    check("break_busy_held", 32'(m_busy), 32'h1);
    check("break_fe_count", 32'(fe_cnt[0] - s_fe), 32'd1);
    check("break_fe_latency", 32'(lat[0]), 32'(2 + CPB / 2 + 9 * CPB + 1));
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("break_busy_released", 32'(m_busy), 32'h0);
    check("break_busy_once", 32'(busy_rise[0] - s_br), 32'd1);
    check("break_no_dv", 32'(dv_cnt[0] - s_dv), 32'd0);
    repeat (2 * CPB) @(posedge clk);
    s_dv = dv_cnt[0];
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("after_break_dv", 32'(dv_cnt[0] - s_dv), 32'd1);
    check("after_break_data", 32'(m_data), 32'hA5);

    // Reset during data bit 3 of a frame that follows a sync word
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("pre_rst_sync", 32'(m_sync), 32'h1);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    #1 rx = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(m_busy), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check("midrst_data", 32'(m_data), 32'h0);
    check("midrst_payload", 32'(m_payload), 32'h0);
    check("midrst_flags", 32'({m_dv, m_pe, m_fe, m_pv, m_busy, m_sync}), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (48) @(posedge clk);
    s_dv = dv_cnt[0];
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("post_rst_dv", 32'(dv_cnt[0] - s_dv), 32'd1);
    check("post_rst_data", 32'(m_data), 32'h55);
    check("post_rst_sync", 32'(m_sync), 32'h1);
    check("post_rst_payload", 32'(m_payload), 32'h0);
    check("post_rst_latency", 32'(lat[0]), 32'(2 + CPB / 2 + 9 * CPB + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
